// File: rtl/mips_ctrl_pkg.sv
// Shared types for the MIPS reset/run-control sequencer: FSM states and counter sizing.
package mips_ctrl_pkg;

  localparam int STATE_W = 3;

  // Hold and stagger counters are sized for the largest supported settings
  localparam int MAX_HOLD_CYCLES = 65536;
  localparam int MAX_STAGGER     = 65536;
  localparam int HOLD_CNT_W      = $clog2(MAX_HOLD_CYCLES);
  localparam int STAGGER_CNT_W   = $clog2(MAX_STAGGER);

  typedef enum logic [STATE_W-1:0] {
    SYNC    = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/reset_sync.sv
// Reset-release synchroniser: asserts asynchronously, releases after STAGES clock edges.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rst_n
);

  logic [STAGES-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= {q[STAGES-2:0], 1'b1};
  end

  assign sync_rst_n = q[STAGES-1];

endmodule

// File: rtl/mips_reset_sequencer.sv
// Staggered multi-channel reset release followed by a bounded run-cycle counter.
// Soft reset is registered once, then restarts the sequence from HOLD without re-synchronising.
module mips_reset_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 1,
  parameter int RUN_CYCLES  = 25,
  parameter int CNT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_soft_rst,
  output logic [NUM_CH-1:0] o_rst_n,
  output logic              o_running,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_cycle_cnt,
  output logic [2:0]        o_state
);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("NUM_CH must be within 1..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > MAX_HOLD_CYCLES) begin : g_bad_hold
    $error("HOLD_CYCLES out of range");
  end
  if (STAGGER < 0 || STAGGER > MAX_STAGGER) begin : g_bad_stagger
    $error("STAGGER out of range");
  end
  if (RUN_CYCLES < 0 || (CNT_W < 31 && RUN_CYCLES >= (1 << CNT_W))) begin : g_bad_run
    $error("RUN_CYCLES must fit in CNT_W bits");
  end

  // HOLD entry edge itself counts toward the hold time
  localparam int HOLD_LAST = (HOLD_CYCLES > 2) ? HOLD_CYCLES - 2 : 0;
  localparam int STG_LAST  = (STAGGER > 0) ? STAGGER - 1 : 0;

  logic                     sync_rst_n;
  logic                     soft_q;
  state_t                   state_q, state_d;
  logic [HOLD_CNT_W-1:0]    hold_q, hold_d;
  logic [STAGGER_CNT_W-1:0] stg_q, stg_d;
  logic [NUM_CH-1:0]        rst_q, rst_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic                     running_q;

  reset_sync #(.STAGES(SYNC_STAGES)) u_reset_sync (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .sync_rst_n (sync_rst_n)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= SYNC;
      soft_q    <= 1'b0;
      hold_q    <= '0;
      stg_q     <= '0;
      rst_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      soft_q    <= i_soft_rst && (state_q != SYNC);
      hold_q    <= hold_d;
      stg_q     <= stg_d;
      rst_q     <= rst_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stg_d   = stg_q;
    rst_d   = rst_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (soft_q) begin
      state_d = HOLD;
      hold_d  = '0;
      stg_d   = '0;
      rst_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        SYNC: begin
          if (sync_rst_n) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
        HOLD: begin
          if (hold_q == HOLD_CNT_W'(HOLD_LAST)) begin
            stg_d = '0;
            if (STAGGER == 0 || NUM_CH == 1) begin
              rst_d   = '1;
              state_d = RUN;
            end else begin
              rst_d   = NUM_CH'(1);
              state_d = RELEASE;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        RELEASE: begin
          if (stg_q == STAGGER_CNT_W'(STG_LAST)) begin
            // Shift in ones so release order stays strictly ascending
            rst_d = (rst_q << 1) | NUM_CH'(1);
            stg_d = '0;
            if (&rst_d) state_d = RUN;
          end else begin
            stg_d = stg_q + 1'b1;
          end
        end
        RUN: begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          if (RUN_CYCLES != 0 && cnt_d == CNT_W'(RUN_CYCLES)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE: begin
        end
        default: state_d = SYNC;
      endcase
    end
  end

  assign o_rst_n     = rst_q;
  assign o_running   = running_q;
  assign o_done      = done_q;
  assign o_cycle_cnt = cnt_q;
  assign o_state     = state_q;

endmodule
